// File: rtl/branch_predict_table.sv
// rtl/branch_predict_table.sv - branch target buffer with saturating direction counters
//
// Fetch-stage branch target buffer. Each entry holds a valid bit, the branch
// PC (key), the last taken target and a CNT_BITS-wide saturating direction
// counter. The fetch PC is looked up every cycle; the execute stage writes
// back resolved outcomes. Misses allocate into the lowest invalid entry, or
// into the round-robin victim when the table is full.
//
// Parameters:
//   ADDR_WIDTH  width of keys and targets
//   DEPTH       number of entries (power of two, >= 2)
//   CNT_BITS    direction counter width (>= 1; 1 gives a last-outcome predictor)
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (wins over everything)
//   flush             invalidate all entries; drops a same-cycle update
//   rd_en, rd_key     lookup request, sampled at the clock edge
//   rd_val            registered predicted target (0 on miss)
//   rd_hit            registered hit flag
//   rd_taken          registered hit & counter MSB
//   upd_en            resolved-branch update strobe
//   upd_key           PC of the resolved branch
//   upd_target        resolved target
//   upd_taken         resolved direction
//   occupancy         number of valid entries
//
// Compile-time option:
//   BTB_BYPASS_EN     when defined, a read and update of the same key at the
//                     same edge returns the post-update entry, and a
//                     same-edge flush forces a miss. When undefined, reads
//                     always see the state from before the edge.

module branch_predict_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int CNT_BITS   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_key,
    output logic [ADDR_WIDTH-1:0]    rd_val,
    output logic                     rd_hit,
    output logic                     rd_taken,
    input  logic                     upd_en,
    input  logic [ADDR_WIDTH-1:0]    upd_key,
    input  logic [ADDR_WIDTH-1:0]    upd_target,
    input  logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      valid;
    logic [ADDR_WIDTH-1:0] key_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] target_q [DEPTH];
    logic [CNT_BITS-1:0]   cnt_q    [DEPTH];
    logic [IDX_W-1:0]      rr_ptr;
    logic [OCC_W-1:0]      occ_q;

    assign occupancy = occ_q;

    // ------------------------------------------------------------------
    // Read-port lookup. Scanning from the top down lets the lowest
    // matching index win if duplicates were ever present.
    // ------------------------------------------------------------------
    logic             rd_match;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        rd_match = 1'b0;
        rd_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (key_q[i] == rd_key)) begin
                rd_match = 1'b1;
                rd_idx   = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Update-port lookup, same lowest-index priority.
    // ------------------------------------------------------------------
    logic             upd_hit;
    logic [IDX_W-1:0] upd_idx;

    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (key_q[i] == upd_key)) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Lowest-index invalid entry, used as the allocation victim before
    // the round-robin pointer is consulted.
    // ------------------------------------------------------------------
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Victim selection and next entry contents for an update.
    // A hit rewrites its own entry; a miss allocates.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      victim;
    logic [CNT_BITS-1:0]   cur_cnt;
    logic [CNT_BITS-1:0]   new_cnt;
    logic [ADDR_WIDTH-1:0] new_target;

    always_comb begin
        if (upd_hit) begin
            victim = upd_idx;
        end else if (free_found) begin
            victim = free_idx;
        end else begin
            victim = rr_ptr;
        end
    end

    assign cur_cnt = cnt_q[upd_idx];

    always_comb begin
        new_cnt    = '0;
        new_target = upd_target;
        if (upd_hit) begin
            if (upd_taken) begin
                new_cnt = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + CNT_BITS'(1);
            end else begin
                new_cnt    = (cur_cnt == '0) ? '0 : cur_cnt - CNT_BITS'(1);
                // A not-taken outcome carries no useful target.
                new_target = target_q[upd_idx];
            end
        end else begin
            // Fresh allocations start strongly biased toward the observed direction.
            new_cnt = upd_taken ? CNT_MAX : '0;
        end
    end

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            rr_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush) begin
            // Keys and targets are left in place; only validity is dropped.
            valid  <= '0;
            rr_ptr <= '0;
            occ_q  <= '0;
        end else if (upd_en) begin
            key_q[victim]    <= upd_key;
            target_q[victim] <= new_target;
            cnt_q[victim]    <= new_cnt;
            valid[victim]    <= 1'b1;
            if (!upd_hit) begin
                // Filling a hole grows occupancy; evicting advances the
                // pointer instead. DEPTH is a power of two, so the
                // increment wraps to 0 on its own.
                if (free_found) begin
                    occ_q <= occ_q + OCC_W'(1);
                end else begin
                    rr_ptr <= rr_ptr + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read result; holds while rd_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hit   <= 1'b0;
            rd_taken <= 1'b0;
            rd_val   <= '0;
        end else if (rd_en) begin
`ifdef BTB_BYPASS_EN
            if (flush) begin
                rd_hit   <= 1'b0;
                rd_taken <= 1'b0;
                rd_val   <= '0;
            end else if (upd_en && (upd_key == rd_key)) begin
                // Forward the entry as it will look after this edge.
                rd_hit   <= 1'b1;
                rd_taken <= new_cnt[CNT_BITS-1];
                rd_val   <= new_target;
            end else begin
                rd_hit   <= rd_match;
                rd_taken <= rd_match & cnt_q[rd_idx][CNT_BITS-1];
                rd_val   <= rd_match ? target_q[rd_idx] : '0;
            end
`else
            rd_hit   <= rd_match;
            rd_taken <= rd_match & cnt_q[rd_idx][CNT_BITS-1];
            rd_val   <= rd_match ? target_q[rd_idx] : '0;
`endif
        end
    end

endmodule

// File: tb/tb_branch_predict_table.sv
// tb/tb_branch_predict_table.sv - self-checking bench for branch_predict_table

module tb_branch_predict_table;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CB    = 2;
    localparam int MAXC  = (1 << CB) - 1;
    localparam int HALF  = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_key = '0;
    logic [AW-1:0] rd_val;
    logic          rd_hit;
    logic          rd_taken;
    logic          upd_en = 1'b0;
    logic [AW-1:0] upd_key = '0;
    logic [AW-1:0] upd_target = '0;
    logic          upd_taken = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;

    branch_predict_table #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rd_en(rd_en), .rd_key(rd_key), .rd_val(rd_val), .rd_hit(rd_hit), .rd_taken(rd_taken),
        .upd_en(upd_en), .upd_key(upd_key), .upd_target(upd_target), .upd_taken(upd_taken),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference table: plain arrays, counter kept as an integer.
    bit            m_valid [DEPTH];
    logic [AW-1:0] m_key   [DEPTH];
    logic [AW-1:0] m_tgt   [DEPTH];
    int            m_cnt   [DEPTH];
    int            m_rr;

    logic          exp_hit;
    logic          exp_taken;
    logic [AW-1:0] exp_val;
    int            exp_occ;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int find(input logic [AW-1:0] k);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    // Drive one cycle of inputs and advance the model to the state that
    // must be visible after the coming edge.
    task automatic step(input logic rst, input logic fl, input logic re, input logic [AW-1:0] rk,
                        input logic ue, input logic [AW-1:0] uk, input logic [AW-1:0] ut,
                        input logic utk);
        int h;
        int v;
        @(negedge clk);
        #1;
        reset = rst; flush = fl; rd_en = re; rd_key = rk;
        upd_en = ue; upd_key = uk; upd_target = ut; upd_taken = utk;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 0; m_key[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
            end
            m_rr = 0;
            exp_hit = 0; exp_taken = 0; exp_val = '0;
        end else begin
            if (re) begin
                h = find(rk);
                exp_hit   = (h >= 0);
                exp_val   = (h >= 0) ? m_tgt[h] : '0;
                exp_taken = (h >= 0) && (m_cnt[h] >= HALF);
            end
            v = -1;
            if (fl) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
                m_rr = 0;
            end else if (ue) begin
                v = find(uk);
                if (v >= 0) begin
                    if (utk) begin
                        m_cnt[v] = (m_cnt[v] + 1 > MAXC) ? MAXC : m_cnt[v] + 1;
                        m_tgt[v] = ut;
                    end else begin
                        m_cnt[v] = (m_cnt[v] - 1 < 0) ? 0 : m_cnt[v] - 1;
                    end
                end else begin
                    for (int i = 0; i < DEPTH && v < 0; i++) if (!m_valid[i]) v = i;
                    if (v < 0) begin
                        v = m_rr;
                        m_rr = (m_rr + 1) % DEPTH;
                    end
                    m_valid[v] = 1; m_key[v] = uk; m_tgt[v] = ut;
                    m_cnt[v] = utk ? MAXC : 0;
                end
            end
`ifdef BTB_BYPASS_EN
            if (re && fl) begin
                exp_hit = 0; exp_taken = 0; exp_val = '0;
            end else if (re && ue && rk == uk) begin
                exp_hit = 1; exp_val = m_tgt[v]; exp_taken = (m_cnt[v] >= HALF);
            end
`endif
        end
        exp_occ = count_valid();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model rd_hit", {31'b0, rd_hit}, {31'b0, exp_hit});
            chk("model rd_taken", {31'b0, rd_taken}, {31'b0, exp_taken});
            chk("model rd_val", rd_val, exp_val);
            chk("model occupancy", AW'(occupancy), AW'(exp_occ));
        end
    end

    task automatic upd(input logic [AW-1:0] k, input logic [AW-1:0] t, input logic tk);
        step(0, 0, 0, '0, 1, k, t, tk);
    endtask

    task automatic rd_lit(input string nm, input logic [AW-1:0] k, input logic h,
                          input logic tk, input logic [AW-1:0] v);
        step(0, 0, 1, k, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        chk({nm, " hit"}, {31'b0, rd_hit}, {31'b0, h});
        chk({nm, " taken"}, {31'b0, rd_taken}, {31'b0, tk});
        chk({nm, " val"}, rd_val, v);
    endtask

    // Call only directly after a step: checks the result of that step's edge.
    task automatic occ_lit(input string nm, input int o);
        @(posedge clk);
        #1;
        chk(nm, AW'(occupancy), AW'(o));
    endtask

    initial begin
        logic [AW-1:0] pool [6];
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108;
        pool[3] = 32'h10c; pool[4] = 32'h200; pool[5] = 32'h204;

        // Reset then read
        step(1, 0, 0, '0, 0, '0, '0, 0);
        chk_en = 1'b1;
        occ_lit("reset occupancy", 0);
        chk("reset rd_hit", {31'b0, rd_hit}, 32'h0);
        chk("reset rd_val", rd_val, 32'h0);
        rd_lit("empty read", 32'h100, 0, 0, 32'h0);

        // Allocate and train
        upd(32'h100, 32'h400, 1);
        rd_lit("alloc taken", 32'h100, 1, 1, 32'h400);
        upd(32'h100, 32'h999, 0);
        rd_lit("nt cnt2", 32'h100, 1, 1, 32'h400);
        upd(32'h100, 32'h999, 0);
        rd_lit("nt cnt1", 32'h100, 1, 0, 32'h400);
        repeat (3) upd(32'h100, 32'h999, 0);
        upd(32'h100, 32'h400, 1);
        rd_lit("floor then taken", 32'h100, 1, 0, 32'h400);

        // Taken retarget and saturation at the top
        repeat (4) upd(32'h100, 32'h500, 1);
        rd_lit("retarget", 32'h100, 1, 1, 32'h500);
        upd(32'h100, 32'h999, 0);
        rd_lit("sat minus one", 32'h100, 1, 1, 32'h500);
        upd(32'h100, 32'h999, 0);
        rd_lit("sat minus two", 32'h100, 1, 0, 32'h500);

        // Fill and evict
        step(1, 0, 0, '0, 0, '0, '0, 0);
        upd(32'h10, 32'h1010, 1);
        upd(32'h20, 32'h1020, 1);
        upd(32'h30, 32'h1030, 1);
        upd(32'h40, 32'h1040, 1);
        occ_lit("full occupancy", 4);
        upd(32'h50, 32'h1050, 1);
        occ_lit("evict occupancy", 4);
        rd_lit("evicted 0x10", 32'h10, 0, 0, 32'h0);
        rd_lit("new 0x50", 32'h50, 1, 1, 32'h1050);
        upd(32'h60, 32'h1060, 0);
        rd_lit("evicted 0x20", 32'h20, 0, 0, 32'h0);
        rd_lit("kept 0x30", 32'h30, 1, 1, 32'h1030);
        rd_lit("new 0x60 nt", 32'h60, 1, 0, 32'h1060);

        // Flush drops a same-cycle update
        step(0, 1, 0, '0, 1, 32'h70, 32'h1070, 1);
        occ_lit("flush occupancy", 0);
        rd_lit("flush dropped", 32'h70, 0, 0, 32'h0);
        rd_lit("flush miss", 32'h30, 0, 0, 32'h0);
        upd(32'h80, 32'h1080, 1);
        occ_lit("post-flush alloc", 1);
        upd(32'h90, 32'h1090, 1);
        upd(32'ha0, 32'h10a0, 1);
        upd(32'hb0, 32'h10b0, 1);
        upd(32'hc0, 32'h10c0, 1);
        rd_lit("entry0 evicted", 32'h80, 0, 0, 32'h0);
        rd_lit("entry1 kept", 32'h90, 1, 1, 32'h1090);

        // Same-edge read and update on an empty table
        step(1, 0, 0, '0, 0, '0, '0, 0);
        step(0, 0, 1, 32'h100, 1, 32'h100, 32'h800, 1);
        @(posedge clk);
        #1;
`ifdef BTB_BYPASS_EN
        chk("same-edge hit", {31'b0, rd_hit}, 32'h1);
        chk("same-edge val", rd_val, 32'h800);
        chk("same-edge taken", {31'b0, rd_taken}, 32'h1);
`else
        chk("same-edge hit", {31'b0, rd_hit}, 32'h0);
        chk("same-edge val", rd_val, 32'h0);
        chk("same-edge taken", {31'b0, rd_taken}, 32'h0);
`endif
        rd_lit("after same-edge", 32'h100, 1, 1, 32'h800);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic rs, fl, re, ue, tk;
            r  = $urandom_range(0, 199);
            rs = (r == 0);
            fl = (r >= 1 && r <= 4);
            re = ($urandom_range(0, 3) != 0);
            ue = ($urandom_range(0, 2) != 0);
            tk = $urandom_range(0, 1);
            step(rs, fl, re, pool[$urandom_range(0, 5)], ue, pool[$urandom_range(0, 5)],
                 $urandom, tk);
        end

        step(0, 0, 0, '0, 0, '0, '0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
